// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch mode controller.
// Holds the state enum, time-word layout and small state-decode helpers.
package stopwatch_pkg;

  localparam int TW = 32;

  // Nibble offsets of each BCD digit inside the time word.
  localparam int MSECL = 0;
  localparam int MSECH = 4;
  localparam int SECL  = 8;
  localparam int SECH  = 12;
  localparam int MINL  = 16;
  localparam int MINH  = 20;
  localparam int HOUL  = 24;
  localparam int HOUH  = 28;

  localparam logic [TW-1:0] TIME_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SPLIT  = 3'd2,
    STOP   = 3'd3,
    RECALL = 3'd4
  } state_t;

  function automatic logic is_running(input state_t s);
    return (s == RUN) || (s == SPLIT);
  endfunction

  function automatic logic is_frozen(input state_t s);
    return (s == SPLIT) || (s == RECALL);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_lap_buffer.sv
// Circular split-time store, read by age (0 = newest); one-cycle write, combinational read.
// No backpressure: a push when full silently overwrites the oldest entry.
module lap_buffer #(
  parameter int DEPTH = 4,
  parameter int TW    = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          clear,
  input  logic [TW-1:0] din,
  input  logic [AW-1:0] rd_idx,
  output logic [TW-1:0] rd_dat,
  output logic [AW:0]   count
);

  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (count != (AW+1)'(DEPTH))
        count <= count + (AW+1)'(1);
    end
  end

  // Entries are never cleared; count alone decides what is reachable.
  always_ff @(posedge clk) begin
    if (push && !reset && !clear)
      mem[wr_ptr] <= din;
  end

  assign rd_addr = wr_ptr - AW'(1) - rd_idx;
  assign rd_dat  = mem[rd_addr];

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM: buttons -> counter enable/clear, split capture, display select.
// Outputs registered one cycle after the button pulse (disp is combinational); no backpressure.
module stopwatch_ctrl #(
  parameter int LAP_DEPTH = 4,
  parameter int TW        = 32,
  localparam int AW       = $clog2(LAP_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_start,
  input  logic          btn_lap,
  input  logic          btn_clear,
  input  logic [TW-1:0] time_in,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic [TW-1:0] disp,
  output logic [AW:0]   lap_cnt,
  output logic          led_run,
  output logic          led_split
);

  import stopwatch_pkg::*;

  state_t        state;
  state_t        state_nxt;
  logic          start_p;
  logic          lap_p;
  logic          clr_p;
  logic          push;
  logic          buf_clr;
  logic          rst_pend;
  logic [AW-1:0] rec_idx;
  logic [TW-1:0] hold;
  logic [TW-1:0] buf_dat;

  // Only the highest-priority pulse survives, even if it has no effect in this state.
  assign start_p = btn_start;
  assign lap_p   = btn_lap & ~btn_start;
  assign clr_p   = btn_clear & ~btn_start & ~btn_lap;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    buf_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start_p)    state_nxt = RUN;
        else if (clr_p) buf_clr = 1'b1;
      end
      RUN: begin
        if (start_p) state_nxt = STOP;
        else if (lap_p) begin
          push      = 1'b1;
          state_nxt = SPLIT;
        end
      end
      SPLIT: begin
        if (start_p)    state_nxt = STOP;
        else if (lap_p) push = 1'b1;
        else if (clr_p) state_nxt = RUN;
      end
      STOP: begin
        if (start_p)                        state_nxt = RUN;
        else if (lap_p && lap_cnt != '0)    state_nxt = RECALL;
        else if (clr_p) begin
          buf_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RECALL: begin
        if (start_p || clr_p) state_nxt = STOP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rst_pend stretches cnt_clr one cycle past reset so the chain starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt_en    <= 1'b0;
      led_run   <= 1'b0;
      led_split <= 1'b0;
      cnt_clr   <= 1'b1;
      rst_pend  <= 1'b1;
      rec_idx   <= '0;
      hold      <= TW'(TIME_ZERO);
    end else begin
      state     <= state_nxt;
      cnt_en    <= is_running(state_nxt);
      led_run   <= is_running(state_nxt);
      led_split <= is_frozen(state_nxt);
      cnt_clr   <= buf_clr | rst_pend;
      rst_pend  <= 1'b0;
      if (push)
        hold <= time_in;
      if (state == STOP && state_nxt == RECALL)
        rec_idx <= '0;
      else if (state == RECALL && lap_p)
        rec_idx <= ((AW+1)'(rec_idx) + (AW+1)'(1) == lap_cnt) ? '0 : rec_idx + AW'(1);
    end
  end

  always_comb begin
    case (state)
      SPLIT:   disp = hold;
      RECALL:  disp = buf_dat;
      default: disp = time_in;
    endcase
  end

  lap_buffer #(
    .DEPTH (LAP_DEPTH),
    .TW    (TW)
  ) u_lap_buffer (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .clear  (buf_clr),
    .din    (time_in),
    .rd_idx (rec_idx),
    .rd_dat (buf_dat),
    .count  (lap_cnt)
  );

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Mode controller for the eight-digit BCD stopwatch datapath: hours, minutes, seconds and centiseconds.
- Turns debounced start/stop, lap and clear pulses into a counter enable and a counter clear.
- Captures split times into a small circular lap buffer and selects what the seven-segment decoders display: live time, frozen split, or a recalled lap.
- Sits between the key debouncers and the BCD counter chain/decoders.

## Interface
- LAP_DEPTH, 4, number of stored lap entries (power of two, 2..8)
- TW, 32, time word width (8 BCD digits, HouH..MsecL, MSB first)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; no other reset
- btn_start  in  1  one-clk debounced pulse, start/stop toggle
- btn_lap  in  1  one-clk debounced pulse, split/recall
- btn_clear  in  1  one-clk debounced pulse, clear/release
- time_in  in  TW  current counter chain value
- cnt_en  out  1  level enable to first counter stage
- cnt_clr  out  1  registered clear pulse to counter chain, active-high
- disp  out  TW  value sent to the digit decoders
- lap_cnt  out  $clog2(LAP_DEPTH)+1  valid entries in lap buffer
- led_run  out  1  high in RUN or SPLIT
- led_split  out  1  high in SPLIT or RECALL

## Operation
- States: IDLE, RUN, SPLIT, STOP, RECALL.
- Button priority when several pulses share a cycle: start > lap > clear. Only the highest-priority pulse acts; the others are dropped.
- IDLE:
  - start → RUN.
  - clear → pulse cnt_clr, empty buffer, stay IDLE.
  - lap is ignored.
- RUN:
  - start → STOP.
  - lap → capture time_in into hold register, push it to the buffer, go to SPLIT.
  - clear is ignored.
- SPLIT (counter keeps running, display frozen):
  - lap → recapture and push, stay SPLIT.
  - clear → RUN (display returns to live).
  - start → STOP.
- STOP:
  - start → RUN.
  - lap with lap_cnt>0 → RECALL at index 0 (newest). Lap with lap_cnt==0 is ignored.
  - clear → pulse cnt_clr, empty buffer (lap_cnt=0), go to IDLE.
- RECALL:
  - lap → index+1, wrapping to 0 at lap_cnt.
  - start or clear → STOP.
- Lap buffer is circular. A push when full overwrites the oldest entry. lap_cnt saturates at LAP_DEPTH.
- Recall index 0 is the most recent push, index k is k pushes older.
- cnt_en = 1 in RUN and SPLIT, else 0.
- disp source by state:
  - IDLE, RUN, STOP: time_in, combinational passthrough.
  - SPLIT: hold register.
  - RECALL: buffer entry at the recall index.

## Timing
- Reset values:
  - state IDLE, cnt_en 0, lap_cnt 0, write pointer 0, recall index 0, hold register 0, led_run 0, led_split 0.
  - cnt_clr = 1 while reset is high and for the first cycle after. It drops on the second clk edge after reset deasserts, so the chain always starts from 00:00:00.00.
- State, cnt_en, led_* and cnt_clr all update on the clk edge that samples the button pulse. They are valid the following cycle.
- Capture samples time_in in the same cycle as the btn_lap pulse. disp shows the captured value from the next cycle.
- cnt_clr is exactly one cycle wide per clear action.
- reset asserted in any state overrides all buttons. The buffer is not cleared beyond lap_cnt=0; stale entries are unreachable.
- No handshake with the datapath. The counter chain must register cnt_en/cnt_clr on clk.

## Structure
- Package stopwatch_pkg holds:
  - state enum (IDLE, RUN, SPLIT, STOP, RECALL).
  - TW constant.
  - digit field offsets (MSECL=0 … HOUH=28).
  - cleared time constant 32'h0000_0000.
- Sub-module lap_buffer holds the circular register file. It has push, clear, write pointer, count and a read port by age index. The FSM and output mux live in stopwatch_ctrl.

## Test plan
- Reset 3 cycles → cnt_clr high through the first post-reset cycle then 0; cnt_en 0; disp==time_in; lap_cnt 0.
- btn_start → cnt_en 1 next cycle. Second btn_start → cnt_en 0, state STOP, led_run 0.
- In RUN, time_in=32'h0012_3456, btn_lap → disp holds 32'h0012_3456 while time_in advances; lap_cnt 1. btn_clear → disp follows time_in again.
- Push 5 laps (values 1..5) with LAP_DEPTH=4, stop, lap ×5 → disp sequence 5, 4, 3, 2, 5; lap_cnt 4.
- btn_start and btn_lap same cycle in RUN → STOP only, lap_cnt unchanged. btn_lap and btn_clear same cycle in STOP with lap_cnt>0 → RECALL, no cnt_clr.
- STOP, btn_clear → single-cycle cnt_clr, state IDLE, lap_cnt 0. Subsequent btn_lap in STOP-from-IDLE path is ignored, with disp==time_in.
